// File: rtl/in256_out1536_flex.sv
// in256_out1536_flex
// Upsizing AXI-Stream width converter: packs 256-bit input beats into one
// 1536-bit output word. The number of beats per word is chosen at run time
// (1..6), and s_axis_tlast closes a partially filled word early. The output
// carries a filled-lane mask so the receiver knows which lanes hold data.

module in256_out1536_flex #(
    parameter int IN_WIDTH = 256,
    parameter int RATIO    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                cfg_beats,
    input  logic [IN_WIDTH-1:0]       s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [IN_WIDTH*RATIO-1:0] m_axis_tdata,
    output logic [RATIO-1:0]          m_axis_tlanes,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int         OUT_WIDTH = IN_WIDTH * RATIO;
    localparam logic [2:0] MAX_BEATS = 3'(RATIO);

    // Lane counter, latched word length and partial-word accumulator
    logic [2:0]           cnt;
    logic [2:0]           len;
    logic [OUT_WIDTH-1:0] acc;

    // Decoded control
    logic [2:0]           cfg_norm;
    logic [2:0]           eff_len;
    logic                 completing;
    logic                 accept;

    // Packed view of the word as it would look if the current beat closed it
    logic [OUT_WIDTH-1:0] packed_word;
    logic [RATIO-1:0]     packed_lanes;

    // Normalise the requested length and decide whether the beat on the bus closes the word
    always_comb begin
        cfg_norm = cfg_beats;
        if ((cfg_beats == 3'd0) || (cfg_beats > MAX_BEATS)) begin
            cfg_norm = MAX_BEATS;
        end
        eff_len    = (cnt == 3'd0) ? cfg_norm : len;
        completing = (cnt == (eff_len - 3'd1)) || s_axis_tlast;
    end

    // Accept anything that does not close a word; a closing beat needs the output register free
    always_comb begin
        s_axis_tready = rst_n & (~completing | ~m_axis_tvalid | m_axis_tready);
        accept        = s_axis_tvalid & s_axis_tready;
    end

    // Build the outgoing word: stored lanes below cnt, the live beat in lane cnt, zeros above
    always_comb begin
        packed_word  = '0;
        packed_lanes = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (3'(k) < cnt) begin
                packed_word[k*IN_WIDTH +: IN_WIDTH] = acc[k*IN_WIDTH +: IN_WIDTH];
                packed_lanes[k]                     = 1'b1;
            end else if (3'(k) == cnt) begin
                packed_word[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
                packed_lanes[k]                     = 1'b1;
            end
        end
    end

    // Lane counter, word length latch, accumulator and the single output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= 3'd0;
            len           <= MAX_BEATS;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlanes <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (cnt == 3'd0) begin
                    len <= cfg_norm;
                end
                if (completing) begin
                    m_axis_tdata  <= packed_word;
                    m_axis_tlanes <= packed_lanes;
                    m_axis_tlast  <= s_axis_tlast;
                    m_axis_tvalid <= 1'b1;
                    cnt           <= 3'd0;
                end else begin
                    acc[cnt*IN_WIDTH +: IN_WIDTH] <= s_axis_tdata;
                    cnt                           <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_in256_out1536_flex.sv
// tb_in256_out1536_flex
// Directed bench for the 256->1536 flexible upsizer. Expected words are pushed
// into a queue when their closing beat is issued; a monitor pops and compares
// every word the DUT hands over.

module tb_in256_out1536_flex;

    logic          clk;
    logic          rst_n;
    logic [2:0]    cfg_beats;
    logic [255:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [1535:0] m_data;
    logic [5:0]    m_lanes;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;

    typedef struct {
        logic [1535:0] data;
        logic [5:0]    lanes;
        logic          last;
    } exp_t;

    exp_t expQ[$];
    int   testsRun;
    int   testsFailed;
    int   stalls;

    in256_out1536_flex dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_beats     (cfg_beats),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .m_axis_tdata  (m_data),
        .m_axis_tlanes (m_lanes),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1535:0] pack6(input logic [255:0] l0, input logic [255:0] l1,
                                            input logic [255:0] l2, input logic [255:0] l3,
                                            input logic [255:0] l4, input logic [255:0] l5);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectWord(input logic [1535:0] d, input logic [5:0] lanes, input logic last);
        exp_t e;
        e.data  = d;
        e.lanes = lanes;
        e.last  = last;
        expQ.push_back(e);
    endtask

    // Drive one beat from the falling edge and hold it until the DUT takes it
    task automatic applyStimulus(input logic [255:0] d, input logic l, input logic [2:0] cfg,
                                 output int waitCycles);
        logic ok;
        waitCycles = 0;
        @(negedge clk);
        s_data    = d;
        s_last    = l;
        cfg_beats = cfg;
        s_valid   = 1'b1;
        forever begin
            #4;
            ok = s_ready;
            @(posedge clk);
            if (ok) break;
            waitCycles++;
            if (waitCycles > 50) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL beat timeout: got no accept expected accept within 50 cycles");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic goIdle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Monitor: every output handshake pops the oldest expected word and compares it lane by lane
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected word: got lanes %b expected no word", m_lanes);
                end else begin
                    e = expQ.pop_front();
                    for (int k = 0; k < 6; k++) begin
                        checkOutput($sformatf("word lane %0d", k), m_data[k*256 +: 256], e.data[k*256 +: 256]);
                    end
                    checkOutput("word lanes mask", 256'(m_lanes), 256'(e.lanes));
                    checkOutput("word tlast", 256'(m_last), 256'(e.last));
                end
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        cfg_beats   = 3'd6;
        s_data      = '0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        m_ready     = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset tvalid", 256'(m_valid), 256'd0);
        checkOutput("reset tlanes", 256'(m_lanes), 256'd0);
        checkOutput("reset tlast", 256'(m_last), 256'd0);
        checkOutput("reset tdata lane0", m_data[255:0], 256'd0);
        checkOutput("ready in reset", 256'(s_ready), 256'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready after reset", 256'(s_ready), 256'd1);

        // Continuous full words, lane values 1..12
        for (int i = 1; i <= 12; i++) begin
            if (i == 6)  expectWord(pack6(1, 2, 3, 4, 5, 6), 6'b111111, 1'b0);
            if (i == 12) expectWord(pack6(7, 8, 9, 10, 11, 12), 6'b111111, 1'b0);
            applyStimulus(256'(i), 1'b0, 3'd6, stalls);
            checkOutput("continuous no stall", 256'(stalls), 256'd0);
            if (i == 6) begin
                #1;
                checkOutput("word0 latency valid", 256'(m_valid), 256'd1);
            end
        end
        goIdle();

        // Backpressure: word0 held while the next word fills, closing beat stalls
        expectWord(pack6(256'h11, 256'h12, 256'h13, 256'h14, 256'h15, 256'h16), 6'b111111, 1'b0);
        expectWord(pack6(256'h17, 256'h18, 256'h19, 256'h1a, 256'h1b, 256'h1c), 6'b111111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(256'(8'h11 + i), 1'b0, 3'd6, stalls);
        end
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(256'(8'h17 + i), 1'b0, 3'd6, stalls);
            checkOutput("backpressure early beat", 256'(stalls), 256'd0);
        end
        @(negedge clk);
        s_data = 256'h1c;
        #4;
        checkOutput("closing beat stalled", 256'(s_ready), 256'd0);
        checkOutput("held word valid", 256'(m_valid), 256'd1);
        checkOutput("held word lane0", m_data[255:0], 256'h11);
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        checkOutput("closing beat released", 256'(s_ready), 256'd1);
        @(posedge clk);
        #1;
        checkOutput("word1 valid next cycle", 256'(m_valid), 256'd1);
        checkOutput("word1 lane5", m_data[1535:1280], 256'h1c);
        goIdle();

        // Short words of two beats
        expectWord(pack6(256'hAAAA, 256'hBBBB, 0, 0, 0, 0), 6'b000011, 1'b0);
        expectWord(pack6(256'hCCCC, 256'hDDDD, 0, 0, 0, 0), 6'b000011, 1'b0);
        applyStimulus(256'hAAAA, 1'b0, 3'd2, stalls);
        applyStimulus(256'hBBBB, 1'b0, 3'd2, stalls);
        applyStimulus(256'hCCCC, 1'b0, 3'd2, stalls);
        applyStimulus(256'hDDDD, 1'b0, 3'd2, stalls);

        // Early tlast, then a single-beat word starting in lane 0
        expectWord(pack6(256'h5A, 256'h5B, 256'h5C, 0, 0, 0), 6'b000111, 1'b1);
        expectWord(pack6(256'h77, 0, 0, 0, 0, 0), 6'b000001, 1'b0);
        applyStimulus(256'h5A, 1'b0, 3'd6, stalls);
        applyStimulus(256'h5B, 1'b0, 3'd6, stalls);
        applyStimulus(256'h5C, 1'b1, 3'd6, stalls);
        applyStimulus(256'h77, 1'b0, 3'd1, stalls);

        // Config change mid-word keeps the latched length; zero normalises to six
        expectWord(pack6(256'h31, 256'h32, 256'h33, 256'h34, 256'h35, 256'h36), 6'b111111, 1'b0);
        expectWord(pack6(256'h41, 256'h42, 256'h43, 0, 0, 0), 6'b000111, 1'b0);
        expectWord(pack6(256'h51, 256'h52, 256'h53, 256'h54, 256'h55, 256'h56), 6'b111111, 1'b0);
        applyStimulus(256'h31, 1'b0, 3'd6, stalls);
        applyStimulus(256'h32, 1'b0, 3'd6, stalls);
        for (int i = 3; i <= 6; i++) applyStimulus(256'(8'h30 + i), 1'b0, 3'd3, stalls);
        for (int i = 1; i <= 3; i++) applyStimulus(256'(8'h40 + i), 1'b0, 3'd3, stalls);
        for (int i = 1; i <= 6; i++) applyStimulus(256'(8'h50 + i), 1'b0, 3'd0, stalls);
        goIdle();

        // Reset mid-word discards the partial lanes
        for (int i = 1; i <= 4; i++) applyStimulus(256'(8'hE0 + i), 1'b0, 3'd6, stalls);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #4;
        checkOutput("ready during mid reset", 256'(s_ready), 256'd0);
        @(posedge clk);
        #1;
        checkOutput("mid reset tvalid", 256'(m_valid), 256'd0);
        checkOutput("mid reset tdata lane0", m_data[255:0], 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expectWord(pack6(256'hF, 256'hF, 256'hF, 256'hF, 256'hF, 256'hF), 6'b111111, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(256'hF, 1'b0, 3'd6, stalls);
        goIdle();

        repeat (5) @(negedge clk);
        checkOutput("all words delivered", 256'(expQ.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/in256_out1536_flex.md
# in256_out1536_flex

Upsizing AXI-Stream width converter that packs 256-bit input beats into one 1536-bit output word. It is the counterpart of the 1536→256 flexible downsizer on the inter-switch 256-bit path. It collects results returned on the 256-bit side back into a 1536-bit word for the inter-switch inputs. The number of beats per word is set at run time (1..6), and `s_axis_tlast` can flush a partial word early.

## Interface
- `IN_WIDTH`, default 256: input beat width.
- `RATIO`, default 6: maximum beats per output word. Output width is `IN_WIDTH*RATIO` = 1536.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `cfg_beats` input 3: beats per output word. Valid values are 1..6; 0 or 7 are treated as 6.
- `s_axis_tdata` input 256: input beat.
- `s_axis_tvalid` input 1: input beat valid.
- `s_axis_tready` output 1: input beat accepted when high together with `s_axis_tvalid`.
- `s_axis_tlast` input 1: closes the current word after this beat.
- `m_axis_tdata` output 1536: packed word. Beat k of a word occupies bits `[256k+255:256k]`, so beat 0 is the LSB lane.
- `m_axis_tlanes` output 6: filled-lane mask; bit k is set when lane k holds data.
- `m_axis_tlast` output 1: the word was closed by `s_axis_tlast`.
- `m_axis_tvalid` output 1: output word valid.
- `m_axis_tready` input 1: downstream accept.

## Operation
- **Datapath:**
  - Lane counter `cnt` (0..5), accumulation register `acc` (1536 bits), and a single output register holding `m_axis_*`.
  - Latched word length `len` (1..6).
- **Word start:** when a beat is accepted with `cnt`=0, `cfg_beats` is sampled into `len` after normalisation.
  - Changes to `cfg_beats` while `cnt`≠0 have no effect on the current word.
  - On the first beat, the effective length is the normalised `cfg_beats` itself.
- **Completing beat:** a beat completes the word when it is the `len`-th beat (`cnt`==`len`-1) or it carries `s_axis_tlast`=1.
- **Non-completing beat:**
  - Write the beat into lane `cnt`, then `cnt`++.
  - Such a beat is always accepted, regardless of the output register state.
- **Completing beat accepted:**
  - The output register loads `acc`, with lane `cnt` replaced by the current beat. All lanes above `cnt` are forced to 0, independent of stale `acc` contents.
  - `m_axis_tlanes` = (2^(`cnt`+1))−1.
  - `m_axis_tlast` = `s_axis_tlast`.
  - `m_axis_tvalid` = 1, `cnt` = 0.
- **Ready rule:**
  - `s_axis_tready` = `rst_n` & (non-completing beat | ~`m_axis_tvalid` | `m_axis_tready`).
  - This is combinational from `cnt`, `len`/`cfg_beats`, `s_axis_tlast`, `m_axis_tvalid` and `m_axis_tready`. There is no combinational path from `s_axis_tvalid` to `s_axis_tready`.
- **Output handshake:**
  - `m_axis_tvalid` stays high, with data, lanes and last stable, until `m_axis_tready`=1.
  - On a transfer with no new completing beat in the same cycle, `m_axis_tvalid` falls.
  - On a simultaneous transfer and completing beat, the register reloads and `m_axis_tvalid` stays 1.
- **Single-beat words:** `cfg_beats`=1 gives one output word per input beat; lanes 1..5 are 0 and `m_axis_tlanes`=000001.
- **`s_axis_tlast` on the `len`-th beat:** a single word with `m_axis_tlast`=1; no extra empty word is produced.

## Timing
- **Reset values** (rst_n=0 at a clock edge):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlanes`=0, `m_axis_tlast`=0.
  - `cnt`=0, `len`=6, `acc`=0.
- **`s_axis_tready` during reset:** 0 while `rst_n`=0, and 1 in the first cycle after release.
- **Reset mid-word:** partially filled lanes are discarded, and a pending output word is dropped without a transfer.
- **Latency:** the completing beat accepted at edge N produces `m_axis_tvalid`=1 in the cycle following edge N (1 cycle).
- **Throughput:** 1 input beat per cycle sustained while `m_axis_tready`=1. Words of 6 beats leave at one word per 6 cycles.
- **Backpressure:**
  - With `m_axis_tvalid`=1 and `m_axis_tready`=0, up to `len`−1 beats of the next word are still accepted.
  - The completing beat then stalls (`s_axis_tready`=0) until `m_axis_tready`=1. It is accepted in that same cycle.

## Test plan
- **Continuous full words:** `cfg_beats`=6, 12 beats with lane values 1..12, `m_axis_tready`=1.
  - `s_axis_tready` stays 1 throughout.
  - Word 0 has lanes 1..6 and valid the cycle after beat 6; word 1 has lanes 7..12.
  - Both words have `m_axis_tlanes`=111111 and `m_axis_tlast`=0.
- **Backpressure:** after word 0, hold `m_axis_tready`=0 and drive 6 more beats.
  - Beats 7..11 are accepted, then `s_axis_tready`=0 on beat 12.
  - Raising `m_axis_tready` transfers word 0 and accepts beat 12 in the same cycle. Word 1 is valid the next cycle.
- **Short words:** `cfg_beats`=2, beats A,B,C,D.
  - Two words {A,B} and {C,D}, with lanes 2..5 = 0 and `m_axis_tlanes`=000011.
- **Early tlast:** `cfg_beats`=6, beats X,Y,Z with `s_axis_tlast` on Z.
  - Word {X,Y,Z,0,0,0} with `m_axis_tlanes`=000111 and `m_axis_tlast`=1.
  - The next beat lands in lane 0.
- **Config change and normalisation:** `cfg_beats` 6→3 after beat 2 of a word; that word still completes at 6 beats, and the next word completes at 3. Separately, `cfg_beats`=0 behaves as 6.
- **Reset mid-word:** 4 beats, then `rst_n`=0 for 1 cycle, then 6 beats of value 0xF.
  - No word is emitted for the first 4 beats.
  - The next word is all lanes 0xF with `m_axis_tlanes`=111111.
